// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types plus the S-box and Rcon helpers used by key_gen.
package aes_pkg;

    localparam int unsigned AES_KEY_W = 128;
    localparam int unsigned AES_NR    = 10;

    typedef logic [AES_KEY_W-1:0] aes_key_t;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse in GF(2^8) as x^254 (0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 9; i++) begin
            if (4'(i) < round) r = xtime(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/key_gen.sv
// Combinational AES-128 key-expansion step: derives round key (round+1) from round key (round).
module key_gen
    import aes_pkg::*;
(
    input  logic [3:0] round,
    input  aes_key_t   key_in,
    output aes_key_t   key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] o0, o1, o2, o3;

    always_comb begin
        w0 = key_in[127:96];
        w1 = key_in[95:64];
        w2 = key_in[63:32];
        w3 = key_in[31:0];
        // SubWord(RotWord(w3)) xor Rcon in the top byte
        temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(round), 24'h000000};
        o0 = w0 ^ temp;
        o1 = w1 ^ o0;
        o2 = w2 ^ o1;
        o3 = w3 ^ o2;
        key_out = {o0, o1, o2, o3};
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion with 11-entry round-key store and registered read port.
// Build option AES_KEY_SCHED_REV_EN adds rd_rev for reversed (decryption-order) reads.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES_NR,
    parameter int unsigned KEY_W = AES_KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_valid,
    input  logic [3:0]       rd_idx,
`ifdef AES_KEY_SCHED_REV_EN
    input  logic             rd_rev,
`endif
    output logic [KEY_W-1:0] rd_key
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] rk_q [NR+1];
    logic [KEY_W-1:0] rk_d [NR+1];
    logic [KEY_W-1:0] rd_key_q, rd_key_d;
    logic [KEY_W-1:0] kg_out;
    logic [3:0]       rd_sel;

    key_gen u_key_gen (
        .round   (cnt_q),
        .key_in  (rk_q[cnt_q]),
        .key_out (kg_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rk_q     <= '{default: '0};
            rd_key_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rk_q     <= rk_d;
            rd_key_q <= rd_key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rk_d    = rk_q;
        unique case (state_q)
            IDLE, READY: begin
                if (key_valid && key_ready) begin
                    rk_d[0] = key_in;
                    cnt_d   = '0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                rk_d[cnt_q + 4'd1] = kg_out;
                if (cnt_q == LAST_IDX - 4'd1) begin
                    cnt_d   = '0;
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_ready  = 1'b0;
        busy       = 1'b0;
        keys_valid = 1'b0;
        unique case (state_q)
            IDLE:   key_ready = 1'b1;
            EXPAND: busy      = 1'b1;
            READY: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Reads sample pre-write storage, so a same-edge write is not visible until the next read.
    always_comb begin
        rd_sel = rd_idx;
`ifdef AES_KEY_SCHED_REV_EN
        if (rd_rev) rd_sel = LAST_IDX - rd_idx;
`endif
        rd_key_d = '0;
        if (rd_idx <= LAST_IDX) rd_key_d = rk_q[rd_sel];
    end

    assign rd_key = rd_key_q;

endmodule
